rs_frame_builder: RTL and testbench

Downstream neighbour of the RS encoder. Consumes RS codewords as an 8-bit AXI-Stream and emits transmit frames, each an attached sync marker (ASM) followed by exactly CW_LEN codeword bytes. Codeword length is enforced: short codewords are zero-padded and long ones truncated, each with an error pulse. One byte per cycle throughput, full backpressure on both sides.

---
 rtl/frame_pkg.sv | 18 +
 rtl/ccsds_randomizer.sv | 36 +++
 rtl/rs_frame_builder.sv | 144 ++++++++++++++
 tb/tb_rs_frame_builder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared state encoding and constants for the RS frame builder.
package frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ASM,
      BODY,
      PAD,
      DROP
   } state_t;

   localparam logic [31:0] ASM_DEFAULT = 32'h1ACFFC1D;

   // h(x) = x^8+x^7+x^5+x^3+1, coefficients x^7..x^0 (x^8 implied)
   localparam logic [7:0] RAND_POLY = 8'hA9;
   localparam logic [7:0] RAND_SEED = 8'hFF;

endpackage

// File: rtl/ccsds_randomizer.sv
// CCSDS pseudo-randomizer, 8 sequence bits per advance.
// Built only when FRAME_RANDOMIZER_EN is defined.
`ifdef FRAME_RANDOMIZER_EN
module ccsds_randomizer
   import frame_pkg::*;
(
   input  logic       core_clk,
   input  logic       rst,
   input  logic       init,
   input  logic       advance,
   output logic [7:0] rnd_byte
);

   // rnd_byte[7] is the oldest sequence bit, so the register is the byte.
   function automatic logic [7:0] step8(input logic [7:0] r);
      logic [7:0] s;
      logic       nb;
      s = r;
      for (int i = 0; i < 8; i++) begin
         nb = 1'b0;
         for (int k = 0; k < 8; k++)
            if (RAND_POLY[k]) nb = nb ^ s[7-k];
         s = {s[6:0], nb};
      end
      return s;
   endfunction

   always_ff @(posedge core_clk) begin
      if (rst || init)
         rnd_byte <= RAND_SEED;
      else if (advance)
         rnd_byte <= step8(rnd_byte);
   end

endmodule
`endif

// File: rtl/rs_frame_builder.sv
// Wraps RS codewords into ASM + fixed-length frames.
// FRAME_RANDOMIZER_EN adds CCSDS randomization of body/pad bytes.
module rs_frame_builder
   import frame_pkg::*;
#(
   parameter int          CW_LEN   = 255,
   parameter int          ASM_LEN  = 4,
   parameter logic [31:0] ASM_WORD = ASM_DEFAULT
) (
   input  logic        core_clk,
   input  logic        rst,
   input  logic [7:0]  s_axis_input_tdata,
   input  logic        s_axis_input_tvalid,
   output logic        s_axis_input_tready,
   input  logic        s_axis_input_tlast,
   output logic [7:0]  m_axis_output_tdata,
   output logic        m_axis_output_tvalid,
   input  logic        m_axis_output_tready,
   output logic        m_axis_output_tlast,
   output logic [15:0] frame_cnt,
   output logic        err_short,
   output logic        err_long
);

   localparam int CW_W = $clog2(CW_LEN + 1);
   localparam logic [CW_W-1:0] CW_MAX = CW_W'(CW_LEN);
   localparam logic [1:0] ASM_LAST = 2'(ASM_LEN - 1);

   state_t          state;
   logic [CW_W-1:0] byte_cnt;
   logic [CW_W-1:0] byte_num;
   logic [1:0]      asm_idx;
   logic [31:0]     asm_sh;
   logic [7:0]      rnd_byte;
   logic            load;

   assign load     = !m_axis_output_tvalid || m_axis_output_tready;
   assign byte_num = byte_cnt + CW_W'(1);
   assign asm_sh   = ASM_WORD << {asm_idx, 3'b000};

   // Reset gating keeps the upstream byte unconsumed during reset.
   assign s_axis_input_tready = !rst &&
      (((state == BODY) && load) || (state == DROP));

`ifdef FRAME_RANDOMIZER_EN
   logic rnd_init;
   logic rnd_adv;

   assign rnd_init = (state == IDLE) && s_axis_input_tvalid;
   assign rnd_adv  = load && (((state == BODY) && s_axis_input_tvalid)
                              || (state == PAD));

   ccsds_randomizer u_rnd (
      .core_clk (core_clk),
      .rst      (rst),
      .init     (rnd_init),
      .advance  (rnd_adv),
      .rnd_byte (rnd_byte)
   );
`else
   assign rnd_byte = 8'h00;
`endif

   always_ff @(posedge core_clk) begin
      if (rst) begin
         state                <= IDLE;
         byte_cnt             <= '0;
         asm_idx              <= '0;
         m_axis_output_tdata  <= 8'h00;
         m_axis_output_tvalid <= 1'b0;
         m_axis_output_tlast  <= 1'b0;
         frame_cnt            <= 16'h0000;
         err_short            <= 1'b0;
         err_long             <= 1'b0;
      end else begin
         err_short <= 1'b0;
         err_long  <= 1'b0;
         if (load) begin
            m_axis_output_tvalid <= 1'b0;
            m_axis_output_tlast  <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (s_axis_input_tvalid) begin
                  state   <= ASM;
                  asm_idx <= '0;
               end
            end
            ASM: begin
               if (load) begin
                  m_axis_output_tdata  <= asm_sh[31:24];
                  m_axis_output_tvalid <= 1'b1;
                  if (asm_idx == ASM_LAST) begin
                     state    <= BODY;
                     byte_cnt <= '0;
                  end else begin
                     asm_idx <= asm_idx + 2'd1;
                  end
               end
            end
            BODY: begin
               if (load && s_axis_input_tvalid) begin
                  m_axis_output_tdata  <= s_axis_input_tdata ^ rnd_byte;
                  m_axis_output_tvalid <= 1'b1;
                  byte_cnt             <= byte_num;
                  if (byte_num == CW_MAX) begin
                     m_axis_output_tlast <= 1'b1;
                     frame_cnt           <= frame_cnt + 16'd1;
                     byte_cnt            <= '0;
                     if (s_axis_input_tlast) begin
                        state <= IDLE;
                     end else begin
                        err_long <= 1'b1;
                        state    <= DROP;
                     end
                  end else if (s_axis_input_tlast) begin
                     err_short <= 1'b1;
                     state     <= PAD;
                  end
               end
            end
            PAD: begin
               if (load) begin
                  m_axis_output_tdata  <= rnd_byte;
                  m_axis_output_tvalid <= 1'b1;
                  byte_cnt             <= byte_num;
                  if (byte_num == CW_MAX) begin
                     m_axis_output_tlast <= 1'b1;
                     frame_cnt           <= frame_cnt + 16'd1;
                     byte_cnt            <= '0;
                     state               <= IDLE;
                  end
               end
            end
            DROP: begin
               if (s_axis_input_tvalid && s_axis_input_tlast)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rs_frame_builder.sv
// Scoreboard bench for rs_frame_builder with a frame-level model.
// Define FRAME_RANDOMIZER_EN to check the randomized build.
module tb_rs_frame_builder;

   localparam int          CW_LEN   = 255;
   localparam int          ASM_LEN  = 4;
   localparam logic [31:0] ASM_WORD = 32'h1ACFFC1D;

   logic        core_clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_tdata = 8'h00;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic        s_tlast = 1'b0;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b1;
   logic        m_tlast;
   logic [15:0] frame_cnt;
   logic        err_short;
   logic        err_long;

   rs_frame_builder #(
      .CW_LEN   (CW_LEN),
      .ASM_LEN  (ASM_LEN),
      .ASM_WORD (ASM_WORD)
   ) dut (
      .core_clk             (core_clk),
      .rst                  (rst),
      .s_axis_input_tdata   (s_tdata),
      .s_axis_input_tvalid  (s_tvalid),
      .s_axis_input_tready  (s_tready),
      .s_axis_input_tlast   (s_tlast),
      .m_axis_output_tdata  (m_tdata),
      .m_axis_output_tvalid (m_tvalid),
      .m_axis_output_tready (m_tready),
      .m_axis_output_tlast  (m_tlast),
      .frame_cnt            (frame_cnt),
      .err_short            (err_short),
      .err_long             (err_long)
   );

   always #5 core_clk = ~core_clk;

   int checks = 0;
   int errors = 0;
   logic [8:0]  exp_q[$];
   int          tl_cyc[$];
   logic [7:0]  ks[CW_LEN];
   logic [7:0]  asm_b[ASM_LEN];
   logic [7:0]  cw[$];
   int cyc = 0;
   int nfr = 0;
   int n_short = 0, n_long = 0;
   int exp_short = 0, exp_long = 0;
   bit rnd_mode = 0;
   bit gap_mode = 0;
   bit prev_stall = 0;
   logic [8:0] prev_out;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Expected frame from the framing rules: ASM, then CW_LEN bytes
   // (truncated or zero-padded), tlast on the final byte.
   function automatic void model(input logic [7:0] c[$]);
      logic [7:0] d;
      for (int i = 0; i < ASM_LEN; i++)
         exp_q.push_back({1'b0, asm_b[i]});
      for (int i = 0; i < CW_LEN; i++) begin
         d = (i < c.size()) ? c[i] : 8'h00;
         exp_q.push_back({i == CW_LEN - 1, d ^ ks[i]});
      end
      if (c.size() < CW_LEN) exp_short++;
      else if (c.size() > CW_LEN) exp_long++;
   endfunction

   function automatic void make_cw(input int len, input int kind);
      cw.delete();
      for (int i = 0; i < len; i++)
         case (kind)
            0: cw.push_back(8'($urandom()));
            1: cw.push_back(8'(i));
            default: cw.push_back(8'h00);
         endcase
   endfunction

   task automatic send_byte(input logic [7:0] d, input logic l);
      bit ok;
      if (gap_mode && ($urandom_range(0, 3) == 0)) begin
         s_tvalid = 1'b0;
         repeat ($urandom_range(1, 3)) @(posedge core_clk);
         #1;
      end
      s_tdata = d;
      s_tlast = l;
      s_tvalid = 1'b1;
      forever begin
         @(negedge core_clk);
         ok = s_tready;
         @(posedge core_clk);
         #1;
         if (ok) break;
      end
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
   endtask

   task automatic send_cw(input logic [7:0] c[$]);
      for (int i = 0; i < c.size(); i++)
         send_byte(c[i], i == c.size() - 1);
   endtask

   task automatic issue(input int len, input int kind);
      make_cw(len, kind);
      model(cw);
      send_cw(cw);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 4000) begin
         @(negedge core_clk);
         n++;
      end
      chk("drain", exp_q.size(), 0);
      repeat (3) @(posedge core_clk);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge core_clk);
         #1;
         m_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge core_clk) begin
      cyc++;
      if (prev_stall) begin
         chk("stall_valid", m_tvalid, 1);
         chk("stall_data", {m_tlast, m_tdata}, prev_out);
      end
      if (m_tvalid && m_tready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", {m_tlast, m_tdata}, 9'h1FF);
         end else begin
            chk("out_byte", {m_tlast, m_tdata}, exp_q.pop_front());
         end
         if (m_tlast) begin
            nfr++;
            chk("frame_cnt", frame_cnt, nfr);
            tl_cyc.push_back(cyc);
         end
      end
      if (err_short) begin
         n_short++;
         chk("short_at_last_real", {m_tvalid, m_tlast}, 2'b10);
      end
      if (err_long) begin
         n_long++;
         chk("long_with_tlast", {m_tvalid, m_tlast}, 2'b11);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out = {m_tlast, m_tdata};
      if (rst) begin
         nfr = 0;
         prev_stall = 0;
      end
   end

   initial begin
      repeat (60000) @(posedge core_clk);
      errors++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      bit s[$];
      int n;
      logic [31:0] w;
      for (int i = 0; i < ASM_LEN; i++) begin
         w = ASM_WORD >> (24 - 8 * i);
         asm_b[i] = w[7:0];
      end
      for (int j = 0; j < CW_LEN; j++) ks[j] = 8'h00;
`ifdef FRAME_RANDOMIZER_EN
      for (int i = 0; i < 8; i++) s.push_back(1'b1);
      while (s.size() < 8 * CW_LEN) begin
         n = s.size();
         s.push_back(s[n-1] ^ s[n-3] ^ s[n-5] ^ s[n-8]);
      end
      for (int j = 0; j < CW_LEN; j++)
         for (int b = 0; b < 8; b++)
            ks[j] = {ks[j][6:0], s[8*j+b]};
`endif

      repeat (3) @(posedge core_clk);
      #1;
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_tlast", m_tlast, 0);
      chk("rst_tready", s_tready, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_errs", {err_short, err_long}, 0);
      rst = 1'b0;
      repeat (2) @(posedge core_clk);
      #1;

      // nominal, back to back, with ASM latency
      tl_cyc.delete();
      make_cw(CW_LEN, 1);
      model(cw);
      model(cw);
      fork
         begin
            send_cw(cw);
            send_cw(cw);
         end
         begin
            @(posedge core_clk);
            #1;
            chk("asm_lat1_valid", m_tvalid, 0);
            @(posedge core_clk);
            #1;
            chk("asm_lat2", {m_tvalid, m_tdata}, {1'b1, asm_b[0]});
         end
      join
      wait_drain();
      chk("period_frames", tl_cyc.size(), 2);
      if (tl_cyc.size() == 2)
         chk("period", tl_cyc[1] - tl_cyc[0], ASM_LEN + CW_LEN + 1);

      // backpressure and gapped input
      rnd_mode = 1;
      gap_mode = 1;
      repeat (3) issue(CW_LEN, 0);
      wait_drain();

      // short codewords
      issue(100, 0);
      issue($urandom_range(1, CW_LEN - 1), 0);
      wait_drain();

      // long codeword, then a clean frame
      issue(300, 0);
      issue(CW_LEN, 0);
      wait_drain();

      // reset at body byte 50
      rnd_mode = 0;
      gap_mode = 0;
      make_cw(CW_LEN, 0);
      for (int i = 0; i < ASM_LEN; i++)
         exp_q.push_back({1'b0, asm_b[i]});
      for (int i = 0; i < 50; i++)
         exp_q.push_back({1'b0, cw[i] ^ ks[i]});
      for (int i = 0; i < 50; i++) send_byte(cw[i], 1'b0);
      s_tdata = cw[50];
      s_tvalid = 1'b1;
      rst = 1'b1;
      @(negedge core_clk);
      chk("rst_mid_tready", s_tready, 0);
      @(posedge core_clk);
      #1;
      rst = 1'b0;
      s_tvalid = 1'b0;
      chk("mid_tvalid", m_tvalid, 0);
      chk("mid_tdata", m_tdata, 0);
      chk("mid_tlast", m_tlast, 0);
      chk("mid_frame_cnt", frame_cnt, 0);
      chk("mid_queue", exp_q.size(), 0);
      exp_q.delete();
      issue(CW_LEN, 0);
      wait_drain();

      // all-zero codewords expose the randomizer sequence
      issue(CW_LEN, 2);
      issue(CW_LEN, 2);
      wait_drain();

      // random lengths under backpressure
      rnd_mode = 1;
      gap_mode = 1;
      for (int f = 0; f < 4; f++)
         case ($urandom_range(0, 2))
            0: issue(CW_LEN, 0);
            1: issue($urandom_range(1, CW_LEN - 1), 0);
            default: issue($urandom_range(CW_LEN + 1, CW_LEN + 40), 0);
         endcase
      wait_drain();
      rnd_mode = 0;
      repeat (4) @(posedge core_clk);
      #1;

      chk("err_short_count", n_short, exp_short);
      chk("err_long_count", n_long, exp_long);
      chk("final_frame_cnt", frame_cnt, nfr);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
